// File: rtl/inst_mem_loader.sv
// Purpose : receives 32-bit instruction words and writes them into a byte-wide instruction
//           array, little-endian, starting at an aligned base address.
// Latency : a word accepted at edge N is written as 4 bytes in the cycles after edges N..N+3;
//           done pulses 1 cycle after the last byte.
// Backpressure: in_ready is high only while waiting for a word, so at most one word is
//           accepted every 5 cycles. A start that would run past the end of memory is
//           refused with a one-cycle err pulse.
// Ports   : clk/reset (sync, active high); start/base_addr/word_count load request;
//           in_valid/in_word/in_ready word stream; mem_we/mem_addr/mem_wdata byte write port;
//           busy level, done and err single-cycle pulses. All outputs are registered.
module inst_mem_loader #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = ADDR_W - 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              in_valid,
   input  logic [31:0]       in_word,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, FINISH} state_t;

   // Wide enough that base + 4*count never overflows before the range check.
   localparam int SUM_W = ADDR_W + CNT_W + 3;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;   // address of byte 0 of the next word
   logic [CNT_W-1:0]  cnt_q;    // words still to be written, including the current one
   logic [23:0]       word_q;   // upper bytes of the current word, shifted down as written
   logic [1:0]        byte_q;   // index of the byte currently on the write port

   logic [ADDR_W-1:0] base_aligned;
   logic [SUM_W-1:0]  load_end;
   logic              start_ok;

   // Masking with ~3 keeps every bit of base_addr in the expression while forcing alignment.
   always_comb begin
      base_aligned = base_addr & ~ADDR_W'(3);
      load_end     = SUM_W'(base_aligned) + (SUM_W'(word_count) << 2);
      start_ok     = (load_end <= (SUM_W'(1) << ADDR_W));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         word_q    <= '0;
         byte_q    <= '0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (!start_ok) begin
                     err <= 1'b1;
                  end else if (word_count == '0) begin
                     state <= FINISH;
                     busy  <= 1'b1;
                     done  <= 1'b1;
                  end else begin
                     state    <= WAIT_WORD;
                     addr_q   <= base_aligned;
                     cnt_q    <= word_count;
                     busy     <= 1'b1;
                     in_ready <= 1'b1;
                  end
               end
            end

            WAIT_WORD: begin
               // in_ready is known high in this state, so in_valid alone marks acceptance.
               if (in_valid) begin
                  state     <= WRITE;
                  in_ready  <= 1'b0;
                  mem_we    <= 1'b1;
                  mem_addr  <= addr_q;
                  mem_wdata <= in_word[7:0];
                  word_q    <= in_word[31:8];
                  byte_q    <= 2'd0;
               end
            end

            WRITE: begin
               if (byte_q == 2'd3) begin
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  addr_q    <= addr_q + ADDR_W'(4);
                  cnt_q     <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     state    <= WAIT_WORD;
                     in_ready <= 1'b1;
                  end
               end else begin
                  byte_q    <= byte_q + 2'd1;
                  mem_addr  <= mem_addr + ADDR_W'(1);
                  mem_wdata <= word_q[7:0];
                  word_q    <= {8'h00, word_q[23:8]};
               end
            end

            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, giving the byte-address width; memory size is 2^ADDR_W bytes (32 by default).
REQ-002 The block SHALL have parameter CNT_W, default ADDR_W-1, giving the word-count width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: the synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle load request.
REQ-006 The block SHALL have port base_addr, input, ADDR_W bits: the first byte address; bits [1:0] are ignored and forced to 0.
REQ-007 The block SHALL have port word_count, input, CNT_W bits: the number of 32-bit words to load.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the source has a word.
REQ-009 The block SHALL have port in_word, input, 32 bits: the instruction word.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the loader accepts in_word this cycle.
REQ-011 The block SHALL have port mem_we, output, 1 bit: the byte write enable to the instruction byte array.
REQ-012 The block SHALL have port mem_addr, output, ADDR_W bits: the byte write address.
REQ-013 The block SHALL have port mem_wdata, output, 8 bits: the byte write data.
REQ-014 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-015 The block SHALL have port done, output, 1 bit: a one-cycle pulse on load completion.
REQ-016 The block SHALL have port err, output, 1 bit: a one-cycle pulse when start is rejected.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT_WORD, WRITE and FINISH, all registered.
REQ-018 In IDLE, start=1 with base_addr[ADDR_W-1:2]*4 + word_count*4 > 2^ADDR_W SHALL pulse err the next cycle and remain in IDLE, with no writes.
REQ-019 In IDLE, a legal start with word_count=0 SHALL go to FINISH, so done pulses the next cycle with no writes.
REQ-020 In IDLE, a legal start with word_count>0 SHALL latch the aligned base address and the count, then go to WAIT_WORD.
REQ-021 start SHALL be ignored in every state other than IDLE.
REQ-022 in_ready SHALL be 1 only in WAIT_WORD; a word is accepted when in_valid and in_ready are both 1 in the same cycle.
REQ-023 On acceptance, the block SHALL latch in_word and go to WRITE; if in_valid stays low, it SHALL wait in WAIT_WORD indefinitely.
REQ-024 WRITE SHALL last exactly 4 cycles with mem_we=1, writing bytes little-endian: cycle k (k=0..3) writes mem_addr=A+k and mem_wdata=word[8k+7:8k].
REQ-025 Latency: for a word accepted at edge N, the byte writes SHALL appear in the 4 cycles following edge N, and in_ready SHALL be 0 during those cycles.
REQ-026 After the 4th byte, A SHALL advance by 4 and the remaining count SHALL decrement; the FSM goes to WAIT_WORD if the count is nonzero, otherwise to FINISH.
REQ-027 FINISH SHALL last 1 cycle with done=1, then return to IDLE.
REQ-028 busy SHALL be 1 in WAIT_WORD, WRITE and FINISH, and 0 in IDLE.
REQ-029 Address arithmetic SHALL be modulo 2^ADDR_W, although a legal load never wraps; a load ending exactly at byte 2^ADDR_W-1 is legal.
REQ-030 mem_addr and mem_wdata SHALL be 0 whenever mem_we=0.
REQ-031 Every output SHALL be driven from registers, with no combinational path from any input to any output.

Reset
REQ-032 When reset=1 at a clock edge, the block SHALL enter IDLE and set in_ready, mem_we, mem_addr, mem_wdata, busy, done and err all to 0.
REQ-033 Reset SHALL take priority over start and in_valid in the same cycle.
REQ-034 Reset in the middle of WRITE SHALL abort the load immediately, leaving bytes already written intact, with no further mem_we and no done pulse.

Verification
REQ-035 The bench SHALL cover this scenario: base_addr=0, word_count=2, words 0x002081B3 then 0x00022103 -> byte writes (0:B3, 1:81, 2:20, 3:00, 4:03, 5:21, 6:02, 7:00), then done for 1 cycle and busy=0.
REQ-036 The bench SHALL cover this scenario: base_addr=28, word_count=1, word 0x00000033 -> writes (28:33, 29:00, 30:00, 31:00), then done; with word_count=2 instead -> an err pulse and no mem_we.
REQ-037 The bench SHALL cover this scenario: base_addr=6, word_count=1, word 0x00000863 -> the address is aligned to 4, giving writes (4:63, 5:08, 6:00, 7:00).
REQ-038 The bench SHALL cover this scenario: in_valid held low for 10 cycles in WAIT_WORD -> in_ready=1 throughout, no writes, busy=1; asserting start meanwhile has no effect.
REQ-039 The bench SHALL cover this scenario: reset asserted during the 2nd byte of WRITE -> the next cycle has mem_we=0, busy=0 and done=0; a new start=1 then loads normally.
REQ-040 The bench SHALL cover this scenario: word_count=0 start -> done the next cycle with no mem_we; back-to-back words with in_valid constantly 1 -> one word accepted every 5 cycles.
